// File: rtl/result_arb_pkg.sv
// Shared constants and types for the result arbiter: arbitration modes, default
// widths, the per-channel pending entry and the output slot state.
package result_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TS_W   = 16;

  // Pending entry at the default widths; the top builds the same layout from its
  // own parameters.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
`ifdef RESULT_ARB_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]   tstamp;
`endif
  } pend_entry_t;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_HOLD = 1'b1
  } slot_state_e;

endpackage

// File: rtl/result_arbiter_if.sv
// Result input strobes plus the registered valid/ready output stream.
// out_tstamp and the TS_W parameter exist only with RESULT_ARB_TIMESTAMP_EN.
interface result_arbiter_if #(
  parameter int NUM_CH = result_arb_pkg::DEF_NUM_CH,
  parameter int DATA_W = result_arb_pkg::DEF_DATA_W
`ifdef RESULT_ARB_TIMESTAMP_EN
  , parameter int TS_W = result_arb_pkg::DEF_TS_W
`endif
);

  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH*DATA_W-1:0]  in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [$clog2(NUM_CH)-1:0] out_ch;
`ifdef RESULT_ARB_TIMESTAMP_EN
  logic [TS_W-1:0]           out_tstamp;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_ch
`ifdef RESULT_ARB_TIMESTAMP_EN
    , out_tstamp
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_ch
`ifdef RESULT_ARB_TIMESTAMP_EN
    , out_tstamp
`endif
  );

endinterface

// File: rtl/result_arbiter_rr_arbiter.sv
// Combinational grant picker: lowest request at or above the pointer, found by a
// priority scan over the request vector doubled to handle wrap-around.
module rr_arbiter
  import result_arb_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ARB_MODE = ARB_FIXED,
  localparam int IDX_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant_oh,
  output logic [IDX_W-1:0]  o_grant_idx
);

  logic [IDX_W-1:0]    w_base;
  logic [2*NUM_CH-1:0] w_req2;
  logic [2*NUM_CH-1:0] w_mask;
  logic [2*NUM_CH-1:0] w_masked;
  logic                w_found;

  // Fixed priority is the rotating search pinned to channel 0.
  assign w_base   = (ARB_MODE == ARB_RR) ? i_ptr : '0;
  assign w_req2   = {i_req, i_req};
  assign w_masked = w_req2 & w_mask;

  always_comb begin
    for (int j = 0; j < 2*NUM_CH; j++) begin
      w_mask[j] = (j >= int'(w_base));
    end
  end

  // NOTE: every output of a combinational block gets a default first, otherwise
  // paths that skip an assignment infer latches.
  always_comb begin
    w_found     = 1'b0;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    for (int j = 0; j < 2*NUM_CH; j++) begin
      if (!w_found && w_masked[j]) begin
        w_found                 = 1'b1;
        o_grant_oh[j % NUM_CH]  = 1'b1;
        o_grant_idx             = IDX_W'(j % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Merges single-cycle result pulses from NUM_CH engines into one registered
// valid/ready stream with one buffered word per channel and sticky drop flags.
// Optional RESULT_ARB_TIMESTAMP_EN adds a capture timestamp carried to out_tstamp.
module result_arbiter
  import result_arb_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ARB_MODE = ARB_FIXED
`ifdef RESULT_ARB_TIMESTAMP_EN
  , parameter int TS_W   = DEF_TS_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  result_arbiter_if.slave   bus,
  output logic [NUM_CH-1:0] ovf_flags,
  input  logic              clear_ovf,
  output logic              busy
);

  localparam int IDX_W = $clog2(NUM_CH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
`ifdef RESULT_ARB_TIMESTAMP_EN
    logic [TS_W-1:0]   tstamp;
`endif
  } entry_t;

  entry_t            r_entry [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_ovf;
  slot_state_e       r_slot;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_ch;
  logic [IDX_W-1:0]  r_ptr;
`ifdef RESULT_ARB_TIMESTAMP_EN
  logic [TS_W-1:0]   r_ts;
  logic [TS_W-1:0]   r_out_ts;
`endif

  logic              w_slot_free;
  logic [NUM_CH-1:0] w_req;
  logic              w_grant_any;
  logic [NUM_CH-1:0] w_grant_oh;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [NUM_CH-1:0] w_capture;
  logic [NUM_CH-1:0] w_drop;

  assign w_slot_free = (r_slot == SLOT_IDLE) || bus.out_ready;
  assign w_req       = w_slot_free ? r_pend : '0;
  assign w_grant_any = |w_req;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  // A channel whose word leaves this cycle can take a new one without loss.
  assign w_capture = bus.in_valid & (~r_pend | w_grant_oh);
  assign w_drop    = bus.in_valid & r_pend & ~w_grant_oh;

  // NOTE: the payload store has no reset; r_pend qualifies every read of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_capture[i]) begin
        r_entry[i].data <= bus.in_data[i*DATA_W +: DATA_W];
`ifdef RESULT_ARB_TIMESTAMP_EN
        r_entry[i].tstamp <= r_ts;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_ovf      <= '0;
      r_slot     <= SLOT_IDLE;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_ptr      <= '0;
`ifdef RESULT_ARB_TIMESTAMP_EN
      r_ts       <= '0;
      r_out_ts   <= '0;
`endif
    end else begin
      r_pend <= (r_pend & ~w_grant_oh) | w_capture;
      // A drop in the clearing cycle still leaves its flag set.
      r_ovf  <= clear_ovf ? w_drop : (r_ovf | w_drop);
`ifdef RESULT_ARB_TIMESTAMP_EN
      r_ts   <= r_ts + TS_W'(1);
`endif
      if (w_slot_free) begin
        if (w_grant_any) begin
          r_slot     <= SLOT_HOLD;
          r_out_data <= r_entry[w_grant_idx].data;
          r_out_ch   <= w_grant_idx;
          r_ptr      <= (w_grant_idx == IDX_W'(NUM_CH-1)) ? '0 : w_grant_idx + IDX_W'(1);
`ifdef RESULT_ARB_TIMESTAMP_EN
          r_out_ts   <= r_entry[w_grant_idx].tstamp;
`endif
        end else begin
          r_slot     <= SLOT_IDLE;
          r_out_data <= '0;
          r_out_ch   <= '0;
`ifdef RESULT_ARB_TIMESTAMP_EN
          r_out_ts   <= '0;
`endif
        end
      end
    end
  end

  assign bus.out_valid = (r_slot == SLOT_HOLD);
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
`ifdef RESULT_ARB_TIMESTAMP_EN
  assign bus.out_tstamp = r_out_ts;
`endif
  assign ovf_flags     = r_ovf;
  assign busy          = (|r_pend) | (r_slot == SLOT_HOLD);

endmodule

// File: tb/tb_result_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share stimulus;
// expected words are queued per instance and popped on each output transfer.
module tb_result_arbiter;
  import result_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        clear_ovf;
  logic [3:0]  ovf_fp, ovf_rr;
  logic        busy_fp, busy_rr;
  logic [15:0] ts_model;

  always #5 clk = ~clk;

  result_arbiter_if #(.NUM_CH(4), .DATA_W(16)
`ifdef RESULT_ARB_TIMESTAMP_EN
    , .TS_W(16)
`endif
  ) bus_fp (), bus_rr ();

  assign bus_fp.in_valid  = in_valid;
  assign bus_fp.in_data   = in_data;
  assign bus_fp.out_ready = out_ready;
  assign bus_rr.in_valid  = in_valid;
  assign bus_rr.in_data   = in_data;
  assign bus_rr.out_ready = out_ready;

  result_arbiter #(.NUM_CH(4), .DATA_W(16), .ARB_MODE(ARB_FIXED)
`ifdef RESULT_ARB_TIMESTAMP_EN
    , .TS_W(16)
`endif
  ) dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp),
    .ovf_flags(ovf_fp), .clear_ovf(clear_ovf), .busy(busy_fp)
  );

  result_arbiter #(.NUM_CH(4), .DATA_W(16), .ARB_MODE(ARB_RR)
`ifdef RESULT_ARB_TIMESTAMP_EN
    , .TS_W(16)
`endif
  ) dut_rr (
    .clk(clk), .reset(reset), .bus(bus_rr),
    .ovf_flags(ovf_rr), .clear_ovf(clear_ovf), .busy(busy_rr)
  );

  typedef struct {
    pend_entry_t e;
    logic [1:0]  ch;
  } exp_t;

  exp_t q_fp[$];
  exp_t q_rr[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Free-running cycle count the timestamps are expected to follow.
  always @(posedge clk) ts_model <= reset ? 16'h0000 : ts_model + 16'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [15:0] d);
    in_valid[ch]         = 1'b1;
    in_data[ch*16 +: 16] = d;
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  // which: 0 = both instances, 1 = fixed-priority only, 2 = round-robin only
  task automatic expect_out(input int which, input logic [15:0] d, input logic [1:0] ch);
    exp_t x;
    x.e.data = d;
`ifdef RESULT_ARB_TIMESTAMP_EN
    x.e.tstamp = ts_model;
`endif
    x.ch = ch;
    if (which != 2) q_fp.push_back(x);
    if (which != 1) q_rr.push_back(x);
  endtask

  task automatic score(input string who, input int which, input logic v, input logic rdy,
                       input logic [15:0] d, input logic [1:0] ch, input logic [15:0] ts);
    exp_t x;
    if (v && rdy) begin
      if ((which == 1) ? (q_fp.size() == 0) : (q_rr.size() == 0)) begin
        check({who, "_unexpected_word"}, {16'h0, d}, 32'hFFFF_FFFF);
      end else begin
        x = (which == 1) ? q_fp.pop_front() : q_rr.pop_front();
        check({who, "_data"}, 32'(d), 32'(x.e.data));
        check({who, "_ch"}, 32'(ch), 32'(x.ch));
`ifdef RESULT_ARB_TIMESTAMP_EN
        check({who, "_tstamp"}, 32'(ts), 32'(x.e.tstamp));
`else
        if (ts != 16'h0) $display("note: unexpected timestamp argument");
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
`ifdef RESULT_ARB_TIMESTAMP_EN
      score("fp", 1, bus_fp.out_valid, out_ready, bus_fp.out_data, bus_fp.out_ch, bus_fp.out_tstamp);
      score("rr", 2, bus_rr.out_valid, out_ready, bus_rr.out_data, bus_rr.out_ch, bus_rr.out_tstamp);
`else
      score("fp", 1, bus_fp.out_valid, out_ready, bus_fp.out_data, bus_fp.out_ch, 16'h0);
      score("rr", 2, bus_rr.out_valid, out_ready, bus_rr.out_data, bus_rr.out_ch, 16'h0);
`endif
    end
  end

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q_fp.size() != 0 || q_rr.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_leftover_words", 32'(q_fp.size() + q_rr.size()), 32'd0);
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_seq [4];
    int guard;
    rr_seq = '{2'd3, 2'd0, 2'd1, 2'd2};
    in_valid = '0; in_data = '0; out_ready = 1'b1; clear_ovf = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_fp_valid", 32'(bus_fp.out_valid), 0);
    check("rst_fp_data",  32'(bus_fp.out_data), 0);
    check("rst_fp_ch",    32'(bus_fp.out_ch), 0);
    check("rst_fp_ovf",   32'(ovf_fp), 0);
    check("rst_fp_busy",  32'(busy_fp), 0);
    check("rst_rr_valid", 32'(bus_rr.out_valid), 0);
    check("rst_rr_ovf",   32'(ovf_rr), 0);
    check("rst_rr_busy",  32'(busy_rr), 0);
    tick();
    reset = 1'b0;

    // Single word: valid exactly one cycle, two edges after the strobe
    send(1, 16'hA5A5); expect_out(0, 16'hA5A5, 2'd1);
    tick(); idle();
    @(negedge clk); check("single_t1_valid", 32'(bus_fp.out_valid), 0);
    tick();
    @(negedge clk);
    check("single_t2_valid", 32'(bus_fp.out_valid), 1);
    check("single_t2_data",  32'(bus_fp.out_data), 32'hA5A5);
    check("single_t2_ch",    32'(bus_fp.out_ch), 1);
    tick();
    @(negedge clk);
    check("single_t3_valid", 32'(bus_fp.out_valid), 0);
    check("single_t3_data",  32'(bus_fp.out_data), 0);
    check("single_t3_busy_fp", 32'(busy_fp), 0);
    check("single_t3_busy_rr", 32'(busy_rr), 0);
    drain(10);

    // Simultaneous ch0/ch2: fixed takes ch0 first; rr pointer sits at 2
    send(0, 16'h1111); send(2, 16'h2222);
    expect_out(1, 16'h1111, 2'd0); expect_out(1, 16'h2222, 2'd2);
    expect_out(2, 16'h2222, 2'd2); expect_out(2, 16'h1111, 2'd0);
    tick(); idle();
    tick();
    @(negedge clk); check("fp_prio_first",  32'(bus_fp.out_data), 32'h1111);
    tick();
    @(negedge clk); check("fp_prio_second", 32'(bus_fp.out_data), 32'h2222);
    drain(10);

    // ch2 alone, then all four together
    send(2, 16'h0C02); expect_out(0, 16'h0C02, 2'd2);
    tick(); idle();
    drain(10);
    for (int k = 0; k < 4; k++) begin
      send(k, 16'h0D00 + 16'(k));
      expect_out(1, 16'h0D00 + 16'(k), 2'(k));
    end
    for (int k = 0; k < 4; k++) expect_out(2, 16'h0D00 + 16'(rr_seq[k]), rr_seq[k]);
    tick(); idle();
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_stream_valid", 32'(bus_rr.out_valid), 1);
      check("rr_stream_ch",    32'(bus_rr.out_ch), 32'(rr_seq[k]));
      tick();
    end
    drain(10);

    // Backpressure: third word on ch1 is dropped
    out_ready = 1'b0;
    send(1, 16'h0001); expect_out(0, 16'h0001, 2'd1); tick();
    send(1, 16'h0002); expect_out(0, 16'h0002, 2'd1); tick();
    send(1, 16'h0003); tick(); idle();
    @(negedge clk);
    check("bp_ovf_fp", 32'(ovf_fp), 32'b0010);
    check("bp_ovf_rr", 32'(ovf_rr), 32'b0010);
    check("bp_busy",   32'(busy_fp), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("bp_hold_valid", 32'(bus_fp.out_valid), 1);
      check("bp_hold_data",  32'(bus_fp.out_data), 32'h0001);
      check("bp_hold_ch",    32'(bus_rr.out_ch), 1);
    end
    out_ready = 1'b1;
    drain(10);
    check("bp_ovf_sticky", 32'(ovf_fp), 32'b0010);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    @(negedge clk); check("clear_ovf_fp", 32'(ovf_fp), 0);
    check("clear_ovf_rr", 32'(ovf_rr), 0);

    // Overflow in the clearing cycle keeps its flag
    out_ready = 1'b0;
    send(3, 16'h0301); expect_out(0, 16'h0301, 2'd3); tick();
    send(3, 16'h0302); expect_out(0, 16'h0302, 2'd3); tick();
    send(3, 16'h0303); clear_ovf = 1'b1; tick(); idle(); clear_ovf = 1'b0;
    @(negedge clk);
    check("clr_vs_ovf_fp", 32'(ovf_fp), 32'b1000);
    check("clr_vs_ovf_rr", 32'(ovf_rr), 32'b1000);
    out_ready = 1'b1;
    drain(10);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;

    // Back-to-back on one channel: full rate, no drops
    for (int k = 0; k < 4; k++) begin
      send(0, 16'h0E00 + 16'(k)); expect_out(0, 16'h0E00 + 16'(k), 2'd0);
      tick();
    end
    idle();
    drain(10);
    check("stream_no_ovf_fp", 32'(ovf_fp), 0);
    check("stream_no_ovf_rr", 32'(ovf_rr), 0);

    // Reset mid-operation discards everything
    out_ready = 1'b0;
    send(0, 16'h0F00); send(1, 16'h0F01); send(2, 16'h0F02); tick();
    idle(); send(1, 16'h0F11); tick(); idle();
    @(negedge clk);
    check("pre_rst_valid", 32'(bus_fp.out_valid), 1);
    check("pre_rst_ovf",   32'(ovf_fp), 32'b0010);
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_fp", 32'(bus_fp.out_valid), 0);
    check("mid_rst_data_fp",  32'(bus_fp.out_data), 0);
    check("mid_rst_busy_fp",  32'(busy_fp), 0);
    check("mid_rst_ovf_fp",   32'(ovf_fp), 0);
    check("mid_rst_valid_rr", 32'(bus_rr.out_valid), 0);
    check("mid_rst_busy_rr",  32'(busy_rr), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      check("post_rst_quiet", 32'(bus_fp.out_valid | bus_rr.out_valid), 0);
    end

`ifdef RESULT_ARB_TIMESTAMP_EN
    // Timestamp captured at counter 0x0010 and held under backpressure
    guard = 0;
    while (ts_model != 16'h0010 && guard < 100) begin tick(); guard++; end
    check("ts_reach_0x10", 32'(ts_model), 32'h0010);
    out_ready = 1'b0;
    send(0, 16'h7000); expect_out(0, 16'h7000, 2'd0); tick(); idle();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("ts_hold_fp", 32'(bus_fp.out_tstamp), 32'h0010);
      tick();
    end
    out_ready = 1'b1;
    drain(10);
    // Counter wrap 0xFFFF -> 0x0000
    guard = 0;
    while (ts_model != 16'hFFFF && guard < 70000) begin tick(); guard++; end
    check("ts_reach_0xffff", 32'(ts_model), 32'hFFFF);
    send(1, 16'h7001); expect_out(0, 16'h7001, 2'd1); tick(); idle();
    send(2, 16'h7002); expect_out(0, 16'h7002, 2'd2); tick(); idle();
    drain(10);
`else
    guard = 0;
    if (guard != 0) $display("note: guard unused");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_arbiter.md
Name: result_arbiter

Overview:
- Parametrised result-merging stage that replaces the fixed two-source output priority mux ahead of FPGA_DATA_OUT / FPGA_OUTPUT_READY.
- Collects result pulses from NUM_CH engines (validator, mac_core, further compute lanes), buffers one word per channel, and arbitrates by fixed priority or round-robin.
- Presents one registered valid/ready output stream tagged with the source channel.
- Detects dropped results per channel.

Parameters:
- NUM_CH, 4, number of result sources; must be >= 2.
- DATA_W, 16, result word width.
- ARB_MODE, 0, 0 = fixed priority (ch0 highest), 1 = round-robin.
- TS_W, 16, timestamp width; used only with RESULT_ARB_TIMESTAMP_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel result strobe, 1 cycle per word.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  selected result.
- out_ch  out  $clog2(NUM_CH)  source channel of out_data.
- ovf_flags  out  NUM_CH  sticky per-channel drop flags.
- clear_ovf  in  1  clears all ovf_flags.
- busy  out  1  high if any pending word exists or out_valid is high.

Behaviour:
- Clock and reset: the only clock is clk. reset is sampled on the clk edge, so it is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ch=0, ovf_flags=0, busy=0, all pend bits=0, round-robin pointer=0. A reset mid-operation discards all pending and output words; no stale word appears after reset.
- Capture:
  - in_valid[i] at edge t sets pend[i] and latches data[i] at t+1.
  - If pend[i] is already set and is not being granted in the same cycle, the new word is dropped, the old word is kept, and ovf_flags[i] is set.
  - If pend[i] is granted in the same cycle as a new in_valid[i], the new word is captured and no overflow is flagged.
- Output slot:
  - The slot is a single register. It is free when out_valid=0 or (out_valid && out_ready).
  - When the slot is free and any pend bit is set, the arbiter grants exactly one channel. The granted data and index load into out_data/out_ch at the next edge, and pend[grant] clears.
- Latency and throughput: minimum latency is 2 cycles from in_valid to out_valid. Throughput is 1 word per cycle under continuous out_ready.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data and out_ch hold stable.
  - out_valid never drops without a transfer, except on reset.
  - When out_valid=0, out_data=0.
- Fixed priority (ARB_MODE=0): the lowest pending index wins.
- Round-robin (ARB_MODE=1):
  - Search starts at the pointer and wraps from NUM_CH-1 to 0.
  - After a grant to channel g, pointer = (g+1) mod NUM_CH.
  - The pointer is unchanged when there is no grant.
- Overflow clear: clear_ovf clears ovf_flags at the next edge. A new overflow in the same cycle as clear_ovf wins, and the flag stays set.
- busy = |pend | out_valid, registered-equivalent (derived from registers only).
- Internal states per channel: EMPTY and PENDING. Output slot states: IDLE and HOLD. Transitions are as described above.

Optional Feature:
- Macro: RESULT_ARB_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TS_W-bit cycle counter, reset to 0 and wrapping at 2^TS_W-1 to 0.
  - Each captured word stores the counter value at its capture edge.
  - Adds output port out_tstamp [TS_W-1:0], which travels with out_data under the same hold rules and resets to 0.
- Undefined: no counter and no out_tstamp port. All other behaviour is identical.

Decomposition:
- Package result_arb_pkg holds:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - A typedef for the per-channel pending entry (data plus optional timestamp).
  - The default width constants.
- Sub-module rr_arbiter:
  - Parametrised by NUM_CH and ARB_MODE.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and binary grant index.
  - Implemented as double-width mask priority pick.
- Top keeps the pend registers, output slot, overflow logic, and pointer update.

Test Plan:
- Single word: in_valid[1] pulse with 0xA5A5, out_ready=1 -> out_valid high exactly 1 cycle at t+2 with out_data=0xA5A5, out_ch=1; busy then 0.
- Fixed priority: ARB_MODE=0, ch0=0x1111 and ch2=0x2222 in the same cycle, out_ready=1 -> 0x1111/ch0 at t+2, 0x2222/ch2 at t+3.
- Round-robin: ARB_MODE=1, ch2 alone is transferred, then all four channels pulse together -> output order ch3, ch0, ch1, ch2, one per cycle.
- Backpressure and overflow:
  - out_ready=0, ch1 pulses 0x0001, 0x0002, 0x0003 on consecutive cycles -> out_data holds 0x0001, pend holds 0x0002, 0x0003 is dropped, ovf_flags=4'b0010.
  - Then raise out_ready -> 0x0001 then 0x0002 are transferred.
  - Then pulse clear_ovf -> ovf_flags=0.
- Reset mid-operation: three channels pending plus out_valid=1, reset held 1 cycle -> next cycle out_valid=0, out_data=0, busy=0, ovf_flags=0, and no output afterwards without new input.
- Timestamp (macro defined): ch0 pulse at counter 0x0010, out_ready=0 for 5 cycles -> out_tstamp=0x0010 held stable until transfer; counter wraps 0xFFFF to 0x0000.
